// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per cycle.
// The InvMixColumns datapath is built only when MIX_COLUMNS_SEQ_INVERSE_EN is defined.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         inverse,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadParam
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

   stateT        stateQ, stateD;
   logic [2:0]   colQ;
   logic [127:0] dataQ;
   logic [127:0] resultQ, resultD;
   logic         modeQ;
   logic         accept;
   logic         lastCol;
   logic [1:0]   colIdx;
   logic [31:0]  colIn, colOut;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mixFwd(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] r [4];
      for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
         r[i] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
      return {r[0], r[1], r[2], r[3]};
   endfunction

`ifdef MIX_COLUMNS_SEQ_INVERSE_EN
   // Coefficients 0e/0b/0d/09 built from shared x2, x4, x8 terms.
   function automatic logic [31:0] mixInv(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] r [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
      end
      for (int i = 0; i < 4; i++) begin
         r[i] = (x8[i] ^ x4[i] ^ x2[i])
              ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
              ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
              ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end
      return {r[0], r[1], r[2], r[3]};
   endfunction
`else
   logic unusedMode;
   assign unusedMode = modeQ;
`endif

   assign accept    = in_valid && (stateQ == StIdle);
   assign lastCol   = (colQ + 3'(COLS_PER_CYCLE)) == 3'd4;
   assign state_out = resultQ;

   always_comb begin
      stateD    = stateQ;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (stateQ)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) stateD = StBusy;
         end
         StBusy: begin
            if (lastCol) stateD = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   // Column c lives at bit lane 3-c, so the lane base is {~c, 5'b0}.
   always_comb begin
      resultD = resultQ;
      colIdx  = '0;
      colIn   = '0;
      colOut  = '0;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         colIdx = colQ[1:0] + 2'(k);
         colIn  = dataQ[{~colIdx, 5'b0} +: 32];
`ifdef MIX_COLUMNS_SEQ_INVERSE_EN
         colOut = modeQ ? mixInv(colIn) : mixFwd(colIn);
`else
         colOut = mixFwd(colIn);
`endif
         resultD[{~colIdx, 5'b0} +: 32] = colOut;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ  <= StIdle;
         colQ    <= '0;
         dataQ   <= '0;
         resultQ <= '0;
         modeQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (accept) begin
            dataQ <= state_in;
            modeQ <= inverse;
            colQ  <= '0;
         end else if (stateQ == StBusy) begin
            resultQ <= resultD;
            colQ    <= colQ + 3'(COLS_PER_CYCLE);
         end
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle), queue scoreboard,
// GF(2^8) reference model. Honours MIX_COLUMNS_SEQ_INVERSE_EN the same way as the design.
module tb_mix_columns_seq;

`ifdef MIX_COLUMNS_SEQ_INVERSE_EN
   localparam bit InvEn = 1'b1;
`else
   localparam bit InvEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n;
   logic [127:0] stateIn;
   logic         inverse;
   logic         inValid  [3];
   logic         outReady [3];
   logic         inReady  [3];
   logic         outValid [3];
   logic [127:0] stateOut [3];

   int compared   = 0;
   int mismatched = 0;
   logic [127:0] expQ [$];

   always #5 clk = ~clk;

   mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
      .state_in(stateIn), .inverse(inverse), .out_valid(outValid[0]),
      .out_ready(outReady[0]), .state_out(stateOut[0]));

   mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
      .state_in(stateIn), .inverse(inverse), .out_valid(outValid[1]),
      .out_ready(outReady[1]), .state_out(stateOut[1]));

   mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
      .state_in(stateIn), .inverse(inverse), .out_valid(outValid[2]),
      .out_ready(outReady[2]), .state_out(stateOut[2]));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
      logic [7:0]   m [4];
      logic [7:0]   acc;
      logic [127:0] o = '0;
      if (inv) begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end else begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - r + 4) % 4], s[127-32*c-8*j -: 8]);
            o[127-32*c-8*r -: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic sendVec(input int u, input logic [127:0] vec, input logic inv,
                          input logic [127:0] exp);
      @(negedge clk);
      stateIn    = vec;
      inverse    = inv;
      inValid[u] = 1'b1;
      check("in_ready_idle", 128'(inReady[u]), 128'd1);
      expQ.push_back(exp);
      @(posedge clk);
      #1;
      inValid[u] = 1'b0;
      stateIn    = ~vec;
      inverse    = ~inv;
      check("in_ready_after_accept", 128'(inReady[u]), 128'd0);
   endtask

   task automatic collect(input int u, input int lat, input int hold);
      int           cycles = 0;
      logic         stable = 1'b1;
      logic [127:0] first;
      logic [127:0] exp;
      while (outValid[u] !== 1'b1 && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check("latency", 128'(cycles), 128'(lat));
      first = stateOut[u];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         inValid[u] = i[0];
         stateIn    = rnd128();
         @(posedge clk);
         #1;
         if (outValid[u] !== 1'b1 || stateOut[u] !== first || inReady[u] !== 1'b0) stable = 1'b0;
      end
      inValid[u] = 1'b0;
      if (hold > 0) check("backpressure_stable", 128'(stable), 128'd1);
      exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      check("state_out", stateOut[u], exp);
      // Release with in_valid also high: must not be accepted in the same edge.
      @(negedge clk);
      outReady[u] = 1'b1;
      inValid[u]  = 1'b1;
      @(posedge clk);
      #1;
      outReady[u] = 1'b0;
      inValid[u]  = 1'b0;
      check("out_valid_release", 128'(outValid[u]), 128'd0);
      check("in_ready_release", 128'(inReady[u]), 128'd1);
   endtask

   initial begin
      logic [127:0] v;
      logic         inv;
      logic         sawValid;
      reset_n = 1'b0;
      stateIn = '0;
      inverse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inValid[i]  = 1'b0;
         outReady[i] = 1'b0;
      end
      #1;
      check("reset_in_ready", 128'(inReady[0]), 128'd1);
      check("reset_out_valid", 128'(outValid[0]), 128'd0);
      check("reset_state_out", stateOut[0], 128'h0);
      check("reset_state_out_c4", stateOut[2], 128'h0);
      #20;
      @(negedge clk);
      reset_n = 1'b1;

      sendVec(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
      collect(0, 4, 10);
      sendVec(2, 128'h49db873b453953897f02d2f177de961a, 1'b0, 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5);
      collect(2, 1, 0);
      sendVec(1, 128'hacc1d6b8efb55a7b1323cfdf457311b5, 1'b0, 128'h75ec0993200b633353c0cf7cbb25d0dc);
      collect(1, 2, 3);

`ifdef MIX_COLUMNS_SEQ_INVERSE_EN
      v = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
      v = model(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0);
`endif
      sendVec(0, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, v);
      collect(0, 4, 0);

      for (int u = 0; u < 3; u++) begin
         for (int n = 0; n < 3; n++) begin
            v   = rnd128();
            inv = 1'($urandom_range(0, 1));
            sendVec(u, v, inv, model(v, inv && InvEn));
            collect(u, 4 >> u, n);
         end
      end

      // Abort mid-BUSY after two columns.
      v = rnd128();
      sendVec(0, v, 1'b0, model(v, 1'b0));
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_in_ready", 128'(inReady[0]), 128'd1);
      check("abort_out_valid", 128'(outValid[0]), 128'd0);
      check("abort_state_out", stateOut[0], 128'h0);
      if (expQ.size() > 0) void'(expQ.pop_front());
      @(negedge clk);
      @(negedge clk);
      reset_n  = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (outValid[0] !== 1'b0) sawValid = 1'b1;
      end
      check("abort_no_result", 128'(sawValid), 128'd0);

      // Accept on the very first edge after reset release.
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n    = 1'b1;
      stateIn    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      inverse    = 1'b0;
      inValid[0] = 1'b1;
      expQ.push_back(128'h046681e5e0cb199a48f8d37a2806264c);
      @(posedge clk);
      #1;
      inValid[0] = 1'b0;
      stateIn    = '0;
      check("first_edge_accept", 128'(inReady[0]), 128'd0);
      collect(0, 4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, columns transformed per BUSY cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, state_in and inverse are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, block accepts a new state this cycle.
REQ-006 SHALL have port state_in, input, 128, AES state; column c = bits [127-32c -: 32], row 0 = MSB byte of each column.
REQ-007 SHALL have port inverse, input, 1, 0 = MixColumns, 1 = InvMixColumns; sampled at acceptance only.
REQ-008 SHALL have port out_valid, output, 1, state_out holds a finished result.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-010 SHALL have port state_out, output, 128, transformed state, same byte layout as state_in.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL accept on the rising edge where in_valid && in_ready: register state_in and inverse, clear column counter, go IDLE -> BUSY.
REQ-013 SHALL, each BUSY cycle, transform COLS_PER_CYCLE consecutive columns starting at column 0, write them into the result register and advance the counter by COLS_PER_CYCLE.
REQ-014 SHALL go BUSY -> DONE on the edge completing column 3; latency from the acceptance edge to out_valid = 4/COLS_PER_CYCLE cycles.
REQ-015 SHALL hold state_out and out_valid stable in DONE while out_ready = 0 (no loss, no change).
REQ-016 SHALL go DONE -> IDLE on the edge where out_ready = 1; in_ready rises in the following cycle.
REQ-017 SHALL ignore in_valid outside IDLE, and changes to state_in/inverse after acceptance.
REQ-018 SHALL compute forward per column with GF(2^8) coefficients {02,03,01,01} rotated, and inverse with {0e,0b,0d,09}, reduction polynomial 0x11b, all bytes 8 bits wide.
REQ-019 SHALL present the full 128-bit result only in DONE; state_out contents outside DONE are don't-care to the consumer.
REQ-020 SHALL make in_valid = 1 and out_ready = 1 in the same cycle act only according to the current state (no same-cycle accept-and-release).
REQ-021 SHALL reject COLS_PER_CYCLE not in {1,2,4} at elaboration.

Reset
REQ-022 SHALL, while reset_n = 0, force state IDLE, counter 0, in_ready = 1, out_valid = 0, state_out = 128'h0, captured mode = 0.
REQ-023 SHALL abort any operation in BUSY or DONE on reset assertion; no result is produced for it after release.
REQ-024 SHALL accept a new state on the first rising edge after reset_n deasserts if in_valid = 1.

Configuration
REQ-025 SHALL compile in the InvMixColumns datapath only when MIX_COLUMNS_SEQ_INVERSE_EN is defined.
REQ-026 SHALL, without MIX_COLUMNS_SEQ_INVERSE_EN, ignore the inverse port and always perform forward MixColumns; ports and timing are unchanged.

Verification
REQ-027 SHALL check forward, COLS_PER_CYCLE=1: state_in d4bf5d30e0b452aeb84111f11e2798e5 -> state_out 046681e5e0cb199a48f8d37a2806264c, out_valid 4 cycles after acceptance.
REQ-028 SHALL check COLS_PER_CYCLE=4: 49db873b453953897f02d2f177de961a -> 584dcaf11b4b5aacdbe7caa81b6bb0e5 with 1-cycle latency; COLS_PER_CYCLE=2: acc1d6b8efb55a7b1323cfdf457311b5 -> 75ec0993200b633353c0cf7cbb25d0dc with 2-cycle latency.
REQ-029 SHALL check, with MIX_COLUMNS_SEQ_INVERSE_EN, inverse=1: 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5; without the macro the same stimulus yields the forward result of that input.
REQ-030 SHALL check backpressure: out_ready = 0 for 10 cycles in DONE -> state_out and out_valid stable, in_ready = 0, extra in_valid pulses ignored; out_ready = 1 -> IDLE next edge.
REQ-031 SHALL check reset mid-BUSY (COLS_PER_CYCLE=1, after 2 columns): outputs return to REQ-022 values asynchronously, no out_valid afterwards, next accepted vector yields the correct result.
